// File: rtl/prog_loader_if.sv
// Load-stream and instruction-memory bundle between the byte source and the loader.
// The master drives the byte stream; the slave is the loader producing imem and status.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: receives a big-endian word count then 4-byte MSB-first words,
// writes them to instruction memory and releases the CPU once the image is complete.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   word_idx, word_idx_nxt;
  logic [1:0]        byte_cnt, byte_cnt_nxt;
  logic [15:0]       len, len_nxt;
  logic [31:0]       asm_word, asm_word_nxt;

  logic              accept;
  logic [16:0]       n_ext;
  logic [ADDR_W:0]   idx_inc;

  assign accept  = bus.rx_valid && bus.rx_ready;
  // Full word count as it will be once the low length byte is taken.
  assign n_ext   = {1'b0, len[15:8], bus.rx_data};
  assign idx_inc = word_idx + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= LEN_HI;
      word_idx <= '0;
      byte_cnt <= '0;
      len      <= '0;
      asm_word <= '0;
    end else begin
      state    <= state_nxt;
      word_idx <= word_idx_nxt;
      byte_cnt <= byte_cnt_nxt;
      len      <= len_nxt;
      asm_word <= asm_word_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_idx_nxt = word_idx;
    byte_cnt_nxt = byte_cnt;
    len_nxt      = len;
    asm_word_nxt = asm_word;
    case (state)
      LEN_HI: begin
        if (accept) begin
          len_nxt   = {bus.rx_data, 8'h00};
          state_nxt = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_nxt = n_ext[15:0];
          if (n_ext == 17'd0)    state_nxt = DONE;
          else if (n_ext > CAP)  state_nxt = ERR;
          else                   state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          asm_word_nxt = {asm_word[23:0], bus.rx_data};
          if (byte_cnt == 2'd3) begin
            byte_cnt_nxt = 2'd0;
            state_nxt    = WRITE;
          end else begin
            byte_cnt_nxt = byte_cnt + 2'd1;
          end
        end
      end
      WRITE: begin
        // The index is one bit wider than the address so a full-capacity image ends cleanly.
        word_idx_nxt = idx_inc;
        state_nxt    = (17'(idx_inc) == {1'b0, len}) ? DONE : DATA;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.rx_ready   = 1'b0;
    bus.imem_we    = 1'b0;
    bus.cpu_hold   = 1'b1;
    bus.load_done  = 1'b0;
    bus.load_err   = 1'b0;
    bus.imem_addr  = word_idx[ADDR_W-1:0];
    bus.imem_wdata = asm_word;
    case (state)
      LEN_HI, LEN_LO, DATA: bus.rx_ready = 1'b1;
      WRITE:                bus.imem_we  = 1'b1;
      DONE: begin
        bus.cpu_hold  = 1'b0;
        bus.load_done = 1'b1;
      end
      ERR:                  bus.load_err = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
